// File: rtl/psram_burst_splitter.sv
// psram_burst_splitter
// Splits one multi-beat bus request into PSRAM segments so that no segment
// crosses a PSRAM page or exceeds the runtime/hard tCEM beat limit.
// Optional segment/split statistics: define PSRAM_SPLIT_STAT_EN.
module psram_burst_splitter #(
  parameter int ADDR_WIDTH    = 32,
  parameter int LEN_WIDTH     = 8,
  parameter int BEAT_BYTES    = 8,
  parameter int PAGE_SIZE     = 1024,
  parameter int MAX_SEG_BEATS = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  cfg_en_i,
  input  logic [LEN_WIDTH-1:0]  cfg_max_beats_i,
`ifdef PSRAM_SPLIT_STAT_EN
  input  logic                  stat_clr_i,
  output logic [15:0]           seg_cnt_o,
  output logic [15:0]           split_cnt_o,
`endif
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [LEN_WIDTH-1:0]  req_len_i,
  input  logic                  req_rdwr_i,
  output logic                  req_done_o,
  output logic                  seg_valid_o,
  input  logic                  seg_ready_i,
  output logic [ADDR_WIDTH-1:0] seg_addr_o,
  output logic [LEN_WIDTH-1:0]  seg_len_o,
  output logic                  seg_rdwr_o,
  output logic                  seg_last_o,
  input  logic                  seg_done_i
);

  localparam int BEAT_BITS = $clog2(BEAT_BYTES);
  localparam int PAGE_BITS = $clog2(PAGE_SIZE);
  localparam int PW        = PAGE_BITS - BEAT_BITS + 1;  // page beat count width
  localparam int RW        = LEN_WIDTH + 1;              // holds 2^LEN_WIDTH beats
  localparam int CW        = (PW > RW) ? PW : RW;        // common compare width

  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_ISSUE, ST_WAIT} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]         rem_q;
  logic                  rdwr_q;
  logic [RW-1:0]         seg_beats_q;

  logic [PAGE_BITS:0]    page_rem;
  logic [CW-1:0]         page_beats;
  logic [RW-1:0]         cfg_plus;
  logic [RW-1:0]         lim;
  logic [RW-1:0]         seg_beats;
  logic                  accept;
  logic                  seg_fire;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state decode plus the handshake outputs that are pure state decodes.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would infer a latch.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    seg_valid_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rst_n_i gating keeps ready low while reset is held.
        req_ready_o = cfg_en_i & rst_n_i;
        if (req_valid_i && cfg_en_i) state_d = ST_CALC;
      end
      ST_CALC:  state_d = ST_ISSUE;
      ST_ISSUE: begin
        seg_valid_o = 1'b1;
        if (seg_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (seg_done_i) state_d = seg_last_o ? ST_IDLE : ST_CALC;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept   = (state_q == ST_IDLE) && req_valid_i && req_ready_o;
  assign seg_fire = seg_valid_o && seg_ready_i;

  // Segment size: min(remaining, beats left in page, beat limit).
  always_comb begin
    page_rem   = (PAGE_BITS + 1)'(PAGE_SIZE) - {1'b0, addr_q[PAGE_BITS-1:0]};
    page_beats = CW'(page_rem >> BEAT_BITS);
    cfg_plus   = {1'b0, cfg_max_beats_i} + RW'(1);
    if (cfg_max_beats_i == '0 || cfg_plus > RW'(MAX_SEG_BEATS)) lim = RW'(MAX_SEG_BEATS);
    else                                                         lim = cfg_plus;
    seg_beats = rem_q;
    if (page_beats < CW'(seg_beats)) seg_beats = RW'(page_beats);
    if (lim < seg_beats)             seg_beats = lim;
  end

  // Request capture, segment registers, address/remaining bookkeeping, done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr_q      <= '0;
      rem_q       <= '0;
      rdwr_q      <= 1'b0;
      seg_beats_q <= '0;
      seg_addr_o  <= '0;
      seg_len_o   <= '0;
      seg_rdwr_o  <= 1'b0;
      seg_last_o  <= 1'b0;
      req_done_o  <= 1'b0;
    end else begin
      req_done_o <= 1'b0;
      if (accept) begin
        addr_q <= req_addr_i & ~ADDR_WIDTH'(BEAT_BYTES - 1);
        rdwr_q <= req_rdwr_i;
        rem_q  <= {1'b0, req_len_i} + RW'(1);
      end
      if (state_q == ST_CALC) begin
        seg_addr_o  <= addr_q;
        seg_len_o   <= LEN_WIDTH'(seg_beats - RW'(1));
        seg_last_o  <= (seg_beats == rem_q);
        seg_rdwr_o  <= rdwr_q;
        seg_beats_q <= seg_beats;
      end
      if (seg_fire) begin
        addr_q <= addr_q + (ADDR_WIDTH'(seg_beats_q) << BEAT_BITS);
        rem_q  <= rem_q - seg_beats_q;
      end
      if (state_q == ST_WAIT && seg_done_i && seg_last_o) req_done_o <= 1'b1;
    end
  end

`ifdef PSRAM_SPLIT_STAT_EN
  logic first_q;

  // Saturating counts of issued segments and of requests split in two or more.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      seg_cnt_o   <= '0;
      split_cnt_o <= '0;
      first_q     <= 1'b0;
    end else begin
      if (accept)        first_q <= 1'b1;
      else if (seg_fire) first_q <= 1'b0;
      if (stat_clr_i) begin
        seg_cnt_o   <= '0;
        split_cnt_o <= '0;
      end else begin
        if (seg_fire && seg_cnt_o != 16'hFFFF) seg_cnt_o <= seg_cnt_o + 16'd1;
        if (seg_fire && first_q && !seg_last_o && split_cnt_o != 16'hFFFF)
          split_cnt_o <= split_cnt_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psram_burst_splitter.sv
// Directed testbench for psram_burst_splitter (default parameters).
module tb_psram_burst_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_en;
  logic [7:0]  cfg_max;
  logic        req_valid;
  logic        req_ready_o;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        req_rdwr;
  logic        req_done_o;
  logic        seg_valid_o;
  logic        seg_ready;
  logic [31:0] seg_addr_o;
  logic [7:0]  seg_len_o;
  logic        seg_rdwr_o;
  logic        seg_last_o;
  logic        seg_done;
`ifdef PSRAM_SPLIT_STAT_EN
  logic        stat_clr = 1'b0;
  logic [15:0] seg_cnt;
  logic [15:0] split_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  psram_burst_splitter dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .cfg_en_i       (cfg_en),
    .cfg_max_beats_i(cfg_max),
`ifdef PSRAM_SPLIT_STAT_EN
    .stat_clr_i     (stat_clr),
    .seg_cnt_o      (seg_cnt),
    .split_cnt_o    (split_cnt),
`endif
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready_o),
    .req_addr_i     (req_addr),
    .req_len_i      (req_len),
    .req_rdwr_i     (req_rdwr),
    .req_done_o     (req_done_o),
    .seg_valid_o    (seg_valid_o),
    .seg_ready_i    (seg_ready),
    .seg_addr_o     (seg_addr_o),
    .seg_len_o      (seg_len_o),
    .seg_rdwr_o     (seg_rdwr_o),
    .seg_last_o     (seg_last_o),
    .seg_done_i     (seg_done)
  );

  // Present a request and hold it until accepted (bounded).
  task automatic send_req(input logic [31:0] a, input logic [7:0] l, input logic rw,
                          output bit ok);
    req_addr = a; req_len = l; req_rdwr = rw; req_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (req_ready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  // Wait (bounded) for seg_valid_o; report edges waited and the segment fields.
  task automatic wait_seg(output bit found, output int cyc, output logic [41:0] f);
    cyc = 0;
    while (!seg_valid_o && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    found = seg_valid_o;
    f     = {seg_addr_o, seg_len_o, seg_last_o, seg_rdwr_o};
  endtask

  task automatic accept_seg();
    seg_ready = 1'b1;
    @(posedge clk); #1;
    seg_ready = 1'b0;
  endtask

  // One idle cycle in WAIT, then a one-cycle seg_done pulse.
  task automatic pulse_done();
    @(posedge clk); #1;
    seg_done = 1'b1;
    @(posedge clk); #1;
    seg_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_en = 1'b1; cfg_max = 8'd0; req_valid = 1'b0;
    req_addr = '0; req_len = '0; req_rdwr = 1'b0; seg_ready = 1'b0; seg_done = 1'b0;
    #12;
    n_cmp++;
    if ({req_ready_o, req_done_o, seg_valid_o, seg_addr_o, seg_len_o, seg_rdwr_o, seg_last_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ready=%b done=%b valid=%b addr=%h len=%h rdwr=%b last=%b want all 0",
               req_ready_o, req_done_o, seg_valid_o, seg_addr_o, seg_len_o, seg_rdwr_o, seg_last_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready_o);
    end
  endtask

  task automatic test_single();
    bit ok, found; int cyc; logic [41:0] f;
    logic [46:0] exp;
    cfg_max = 8'd0;
    send_req(32'h0, 8'd15, 1'b1, ok);
    wait_seg(found, cyc, f);
    exp = {1'b1, 4'd1, 32'h0, 8'd15, 1'b1, 1'b1};
    n_cmp++;
    if ({found, 4'(cyc), f} !== exp || !ok) begin
      n_bad++; $display("FAIL single_seg: got %h want %h (accepted=%b)", {found, 4'(cyc), f}, exp, ok);
    end
    accept_seg();
    n_cmp++;
    if ({seg_valid_o, req_ready_o} !== 2'b00) begin
      n_bad++; $display("FAIL single_wait: got valid/ready %b want 00", {seg_valid_o, req_ready_o});
    end
    pulse_done();
    n_cmp++;
    if (req_done_o !== 1'b1) begin
      n_bad++; $display("FAIL single_done: got %b want 1", req_done_o);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({req_done_o, req_ready_o} !== 2'b01) begin
      n_bad++; $display("FAIL single_done_end: got done/ready %b want 01", {req_done_o, req_ready_o});
    end
  endtask

  task automatic test_page_cross();
    bit ok, found; int cyc; logic [41:0] f;
    logic [41:0] exp_f [2];
    exp_f[0] = {32'h3F0, 8'd1, 1'b0, 1'b0};
    exp_f[1] = {32'h400, 8'd5, 1'b1, 1'b0};
    send_req(32'h3F0, 8'd7, 1'b0, ok);
    for (int i = 0; i < 2; i++) begin
      wait_seg(found, cyc, f);
      n_cmp++;
      if ({found, 4'(cyc), f} !== {1'b1, 4'd1, exp_f[i]}) begin
        n_bad++; $display("FAIL page_seg%0d: got %h want %h", i, {found, 4'(cyc), f}, {1'b1, 4'd1, exp_f[i]});
      end
      accept_seg();
      pulse_done();
      n_cmp++;
      if (req_done_o !== (i == 1)) begin
        n_bad++; $display("FAIL page_done%0d: got %b want %b", i, req_done_o, (i == 1));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_max_beats();
    bit ok, found; int cyc; logic [41:0] f;
    logic [41:0] exp_f [3];
    exp_f[0] = {32'h000, 8'd15, 1'b0, 1'b1};
    exp_f[1] = {32'h080, 8'd15, 1'b0, 1'b1};
    exp_f[2] = {32'h100, 8'd7,  1'b1, 1'b1};
    send_req(32'h0, 8'd39, 1'b1, ok);
    for (int i = 0; i < 3; i++) begin
      wait_seg(found, cyc, f);
      n_cmp++;
      if ({found, 4'(cyc), f} !== {1'b1, 4'd1, exp_f[i]}) begin
        n_bad++; $display("FAIL maxb_seg%0d: got %h want %h", i, {found, 4'(cyc), f}, {1'b1, 4'd1, exp_f[i]});
      end
      accept_seg();
      pulse_done();
      n_cmp++;
      if (req_done_o !== (i == 2)) begin
        n_bad++; $display("FAIL maxb_done%0d: got %b want %b", i, req_done_o, (i == 2));
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_runtime_limit();
    bit ok, found; int cyc; logic [41:0] f;
    logic [41:0] exp_f [3];
    exp_f[0] = {32'h020, 8'd3, 1'b0, 1'b1};
    exp_f[1] = {32'h040, 8'd3, 1'b0, 1'b1};
    exp_f[2] = {32'h060, 8'd1, 1'b1, 1'b1};
    cfg_max = 8'd3;
    send_req(32'h20, 8'd9, 1'b1, ok);
    for (int i = 0; i < 3; i++) begin
      wait_seg(found, cyc, f);
      n_cmp++;
      if ({found, 4'(cyc), f} !== {1'b1, 4'd1, exp_f[i]}) begin
        n_bad++; $display("FAIL lim_seg%0d: got %h want %h", i, {found, 4'(cyc), f}, {1'b1, 4'd1, exp_f[i]});
      end
      if (i == 1) begin
        for (int k = 0; k < 5; k++) begin
          @(posedge clk); #1;
          n_cmp++;
          if ({seg_valid_o, seg_addr_o, seg_len_o, seg_last_o, seg_rdwr_o} !== {1'b1, exp_f[1]}) begin
            n_bad++;
            $display("FAIL lim_hold%0d: got %h want %h", k,
                     {seg_valid_o, seg_addr_o, seg_len_o, seg_last_o, seg_rdwr_o}, {1'b1, exp_f[1]});
          end
        end
      end
      accept_seg();
      pulse_done();
      n_cmp++;
      if (req_done_o !== (i == 2)) begin
        n_bad++; $display("FAIL lim_done%0d: got %b want %b", i, req_done_o, (i == 2));
      end
    end
    cfg_max = 8'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_disable_stray();
    bit ok, found, seen; int cyc; logic [41:0] f;
    cfg_en = 1'b0; req_valid = 1'b1; req_addr = 32'h0; req_len = 8'd0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= req_ready_o | seg_valid_o;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++; $display("FAIL disabled: got ready/valid activity %b want 0", seen);
    end
    req_valid = 1'b0; cfg_en = 1'b1;
    seg_done = 1'b1;
    @(posedge clk); #1;
    seg_done = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({req_ready_o, seg_valid_o, req_done_o} !== 3'b100) begin
      n_bad++; $display("FAIL stray_idle: got ready/valid/done %b want 100", {req_ready_o, seg_valid_o, req_done_o});
    end
    // Stray done while ISSUE, then disable mid-request.
    send_req(32'h4D, 8'd0, 1'b0, ok);
    wait_seg(found, cyc, f);
    seg_done = 1'b1;
    @(posedge clk); #1;
    seg_done = 1'b0;
    n_cmp++;
    if ({found, seg_valid_o, f} !== {1'b1, 1'b1, 32'h48, 8'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL stray_issue: got %h want %h", {found, seg_valid_o, f}, {1'b1, 1'b1, 32'h48, 8'd0, 1'b1, 1'b0});
    end
    accept_seg();
    cfg_en = 1'b0;
    pulse_done();
    n_cmp++;
    if ({req_done_o, req_ready_o} !== 2'b10) begin
      n_bad++; $display("FAIL disable_mid: got done/ready %b want 10", {req_done_o, req_ready_o});
    end
    cfg_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_full_length();
    bit ok, found; int cyc; logic [41:0] f;
    logic [41:0] exp;
    send_req(32'h0, 8'hFF, 1'b1, ok);
    for (int i = 0; i < 16; i++) begin
      wait_seg(found, cyc, f);
      exp = {32'(i * 128), 8'd15, (i == 15), 1'b1};
      n_cmp++;
      if ({found, 4'(cyc), f} !== {1'b1, 4'd1, exp}) begin
        n_bad++; $display("FAIL full_seg%0d: got %h want %h", i, {found, 4'(cyc), f}, {1'b1, 4'd1, exp});
      end
      accept_seg();
      pulse_done();
    end
    n_cmp++;
    if (req_done_o !== 1'b1) begin
      n_bad++; $display("FAIL full_done: got %b want 1", req_done_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    bit ok, found; int cyc; logic [41:0] f;
    send_req(32'h0, 8'd39, 1'b1, ok);
    wait_seg(found, cyc, f);
    accept_seg();
    pulse_done();
    wait_seg(found, cyc, f);
    accept_seg();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({req_ready_o, req_done_o, seg_valid_o, seg_addr_o, seg_len_o, seg_rdwr_o, seg_last_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got ready=%b done=%b valid=%b addr=%h len=%h rdwr=%b last=%b want all 0",
               req_ready_o, req_done_o, seg_valid_o, seg_addr_o, seg_len_o, seg_rdwr_o, seg_last_o);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send_req(32'h0, 8'd0, 1'b1, ok);
    wait_seg(found, cyc, f);
    n_cmp++;
    if ({found, 4'(cyc), f} !== {1'b1, 4'd1, 32'h0, 8'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL post_reset_seg: got %h want %h", {found, 4'(cyc), f}, {1'b1, 4'd1, 32'h0, 8'd0, 1'b1, 1'b1});
    end
    accept_seg();
    pulse_done();
    n_cmp++;
    if (req_done_o !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_done: got %b want 1", req_done_o);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_page_cross();
    test_max_beats();
    test_runtime_limit();
    test_disable_stray();
    test_full_length();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psram_burst_splitter.md
Name: psram_burst_splitter

Overview:
- Parametrised segment scheduler between the AXI4 slave FSM and `psram_core`.
- Accepts one multi-beat bus request of up to 2^LEN_WIDTH beats and splits it into PSRAM segments.
- No segment crosses a PSRAM page boundary or exceeds a configurable maximum beat count (tCEM limit).
- Replaces the fixed single-beat transfer issue path. Adds burst support, page-boundary splitting and runtime CE-time limiting.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LEN_WIDTH, 8, request length field width (beats minus one, AXI style).
- BEAT_BYTES, 8, bytes per beat; power of two.
- PAGE_SIZE, 1024, PSRAM page size in bytes; power of two, at least BEAT_BYTES.
- MAX_SEG_BEATS, 16, hard maximum beats per segment; power of two, at most 2^LEN_WIDTH.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- cfg_en_i  in  1  block enable
- cfg_max_beats_i  in  LEN_WIDTH  runtime segment beat limit, minus one; 0 means use MAX_SEG_BEATS
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted
- req_addr_i  in  ADDR_WIDTH  start byte address
- req_len_i  in  LEN_WIDTH  beats minus one
- req_rdwr_i  in  1  1 = read, 0 = write
- req_done_o  out  1  one-cycle pulse when the final segment completes
- seg_valid_o  out  1  segment valid
- seg_ready_i  in  1  core accepts segment
- seg_addr_o  out  ADDR_WIDTH  segment start byte address
- seg_len_o  out  LEN_WIDTH  segment beats minus one
- seg_rdwr_o  out  1  copy of request direction
- seg_last_o  out  1  final segment of the request
- seg_done_i  in  1  core finished the current segment (one-cycle pulse)

Behaviour:
- Reset is asynchronous, active-low. All outputs reset to 0; state resets to IDLE; internal address and remaining counters reset to 0.
- Address alignment: low log2(BEAT_BYTES) bits of req_addr_i are forced to 0 on capture.
- States: IDLE, CALC, ISSUE, WAIT.
- IDLE:
  - req_ready_o = cfg_en_i (combinational).
  - On req_valid_i && req_ready_o: capture addr, rdwr, and remaining = req_len_i + 1 (LEN_WIDTH+1 bits); go to CALC.
- CALC (1 cycle):
  - page_beats = (PAGE_SIZE - (addr mod PAGE_SIZE)) / BEAT_BYTES.
  - lim = (cfg_max_beats_i == 0) ? MAX_SEG_BEATS : min(cfg_max_beats_i + 1, MAX_SEG_BEATS).
  - seg_beats = min(remaining, page_beats, lim).
  - Register seg_addr_o = addr, seg_len_o = seg_beats - 1, seg_last_o = (seg_beats == remaining), seg_rdwr_o = rdwr.
  - Go to ISSUE.
- ISSUE:
  - seg_valid_o = 1. All seg_* outputs are held stable while seg_valid_o && !seg_ready_i.
  - On seg_ready_i: seg_valid_o drops next cycle; addr += seg_beats * BEAT_BYTES (wraps modulo 2^ADDR_WIDTH); remaining -= seg_beats; go to WAIT.
- WAIT:
  - On seg_done_i: if seg_last_o, pulse req_done_o for 1 cycle and go to IDLE; otherwise go to CALC.
- Latency: request accept to first seg_valid_o is 2 cycles. seg_done_i to next seg_valid_o is 2 cycles.
- seg_done_i outside WAIT is ignored.
- cfg_en_i deasserted mid-request: the current request completes; only new acceptance is blocked.
- cfg_max_beats_i is sampled only in CALC, so changes affect the next segment only.
- Full-length request (req_len_i all ones): remaining = 2^LEN_WIDTH, with no overflow.
- req_ready_o is 0 in every state except IDLE. Only one request is in flight.

Optional Feature:
- Macro: PSRAM_SPLIT_STAT_EN.
- With the macro defined:
  - Adds output seg_cnt_o [15:0], a saturating count of segments issued (incremented on seg_valid_o && seg_ready_i, saturates at 16'hFFFF).
  - Adds output split_cnt_o [15:0], a saturating count of requests that needed more than one segment (incremented when a non-last segment is accepted and it is the first segment of its request).
  - Both counters reset to 0 and are cleared by input stat_clr_i.
- Without the macro: these ports and registers do not exist; all other behaviour is identical.

Test Plan (BEAT_BYTES=8, PAGE_SIZE=1024, MAX_SEG_BEATS=16):
- Single segment: addr 0x0, len 15, read, cfg_max_beats_i 0 -> one segment addr 0x0, len 15, last 1; req_done_o pulses one cycle after seg_done_i.
- Page crossing: addr 0x3F0, len 7, write -> segment 1 addr 0x3F0, len 1, last 0; segment 2 addr 0x400, len 5, last 1; seg_rdwr_o 0 on both.
- Max-beat limit: addr 0x0, len 39 -> segments (0x0, 15), (0x80, 15), (0x100, 7); last set only on the third.
- Runtime limit with backpressure: cfg_max_beats_i 3, addr 0x20, len 9 -> segments (0x20, 3), (0x40, 3), (0x60, 1). Hold seg_ready_i low 5 cycles on the second segment -> seg_* outputs stable throughout.
- Disable and stray done: cfg_en_i 0 -> req_ready_o 0, no segments issued. A seg_done_i pulse in IDLE or ISSUE -> no state change.
- Reset mid-WAIT: assert rst_n_i low during WAIT of a 3-segment request -> all outputs 0 immediately (asynchronous); after release, a new request addr 0x0, len 0 -> one segment (0x0, 0, last 1).
